npu_config_loader: RTL and testbench
====================================

Name: npu_config_loader

Overview:
- Sits directly upstream of the NPU state machine on the configuration path. Drains 16-bit command words from the NPU config FIFO while the state machine reports the config state.
- Decodes each command and produces the state machine's count-register load pulses (npu_state_data_in with input/output reg enables).
- Streams weight payload words to the NPU weight memory write port.
- Decodes one FIFO word per cycle; back-to-back reads are supported.

Parameters:
- WADDR_W, 10, width of the weight memory address; wraps modulo 2^WADDR_W.
- DATA_W, 16, config word and weight data width; must be 16 to match npu_state_data_in.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- npu_state_config  in  1  state machine is in config state; permits FIFO reads.
- npu_config_fifo_empty  in  1  config FIFO empty.
- npu_config_fifo_dout  in  16  config FIFO read data; valid the cycle after a read.
- npu_config_fifo_read_en  out  1  config FIFO read strobe.
- npu_state_data_in  out  16  count value to the state machine.
- npu_state_input_reg_enable  out  1  one-cycle load pulse for the input count.
- npu_state_output_reg_enable  out  1  one-cycle load pulse for the output count.
- npu_weight_wr_en  out  1  weight memory write strobe.
- npu_weight_wr_addr  out  WADDR_W  weight write address.
- npu_weight_wr_data  out  16  weight write data.
- npu_cfg_busy  out  1  command partially decoded or read in flight.
- npu_cfg_error  out  1  sticky illegal-opcode flag.

Behaviour:
- Read strobe (combinational): npu_config_fifo_read_en = npu_state_config & ~npu_config_fifo_empty.
- Read pipeline: rd_valid <= read_en (registered). When rd_valid=1, npu_config_fifo_dout is consumed that cycle regardless of npu_state_config, so no word is lost when config drops.
- Header format: [15:12] opcode, [11:0] field.
- Decoder FSM states: HDR, ARG_IN, ARG_OUT, WGT. Transitions occur only on cycles with rd_valid=1; otherwise the state holds. Reset state is HDR.
- HDR, by opcode:
  - 0x0 NOP: stay in HDR.
  - 0x1: go to ARG_IN.
  - 0x2: go to ARG_OUT.
  - 0x3 LOAD_WEIGHTS: wgt_rem <= field[11:0]. Go to WGT if field≠0; stay in HDR if field=0.
  - 0x4 SET_WADDR: waddr <= field[WADDR_W-1:0]; stay in HDR.
  - 0x5–0xF: npu_cfg_error <= 1; word discarded; stay in HDR.
- ARG_IN: next cycle, npu_state_data_in <= word and npu_state_input_reg_enable=1 for exactly one cycle; go to HDR.
- ARG_OUT: same as ARG_IN, but pulses npu_state_output_reg_enable.
- WGT: next cycle, npu_weight_wr_en=1, wr_data=word, wr_addr=waddr; then waddr <= waddr+1 (wraps), wgt_rem <= wgt_rem-1. Go to HDR when wgt_rem==1.
- Latency: read_en at cycle t → word consumed at t+1 → reg enable / weight write visible at t+2. Enables and write are registered pulses, deasserted in every cycle without a consumed argument or payload word.
- npu_state_data_in holds its last loaded value between pulses.
- npu_cfg_busy (combinational) = (state≠HDR) | rd_valid.
- Config dropped mid-command (FIFO empty): FSM holds state, wgt_rem and waddr, and resumes on the next word after re-entry.
- Weight count 4095 is the maximum payload per header.
- Reset values: all outputs 0; state=HDR, rd_valid=0, waddr=0, wgt_rem=0, error cleared. A word whose read was issued in the cycle RST is asserted is discarded.

Test Plan:
- FIFO holds 0x1000, 0x0008, 0x2000, 0x0004, config=1 → read_en 4 consecutive cycles; input_reg_enable pulse with data_in=0x0008 at t+2 of the 2nd read; output_reg_enable pulse with data_in=0x0004 two cycles after the 4th read.
- Words 0x4010, 0x3003, 0xA1, 0xA2, 0xA3 → three writes: addr 0x010/0x011/0x012, data 0x00A1/0x00A2/0x00A3; FSM returns to HDR and busy=0 afterwards.
- WADDR=0x3FE via 0x43FE, then 0x3003 with 3 payload words → write addresses 0x3FE, 0x3FF, 0x000 (wrap).
- 0x3002, 0xB1, FIFO empty, config=0 for 5 cycles, config=1, 0xB2 → 2nd write (data 0xB2, addr = first addr+1) occurs after resume; busy=1 during the gap.
- 0x7123 then 0x1000, 0x0005 → cfg_error=1 and stays 1; input load with 0x0005 still occurs; 0x3000 produces no writes.
- RST asserted mid-WGT (wgt_rem=2) → next cycle all outputs 0, state HDR; the following word is decoded as a header.

Source files
------------

// File: rtl/npu_config_loader_if.sv
// Configuration-path bundle between the NPU config loader, the config FIFO,
// the NPU state machine count registers and the weight memory write port.
interface npu_config_loader_if #(
    parameter int unsigned WADDR_W = 10,
    parameter int unsigned DATA_W  = 16
);
    logic               npu_state_config;
    logic               npu_config_fifo_empty;
    logic [DATA_W-1:0]  npu_config_fifo_dout;
    logic               npu_config_fifo_read_en;
    logic [DATA_W-1:0]  npu_state_data_in;
    logic               npu_state_input_reg_enable;
    logic               npu_state_output_reg_enable;
    logic               npu_weight_wr_en;
    logic [WADDR_W-1:0] npu_weight_wr_addr;
    logic [DATA_W-1:0]  npu_weight_wr_data;
    logic               npu_cfg_busy;
    logic               npu_cfg_error;

    // Loader side
    modport master (
        input  npu_state_config,
        input  npu_config_fifo_empty,
        input  npu_config_fifo_dout,
        output npu_config_fifo_read_en,
        output npu_state_data_in,
        output npu_state_input_reg_enable,
        output npu_state_output_reg_enable,
        output npu_weight_wr_en,
        output npu_weight_wr_addr,
        output npu_weight_wr_data,
        output npu_cfg_busy,
        output npu_cfg_error
    );

    // FIFO / state machine / weight memory side
    modport slave (
        output npu_state_config,
        output npu_config_fifo_empty,
        output npu_config_fifo_dout,
        input  npu_config_fifo_read_en,
        input  npu_state_data_in,
        input  npu_state_input_reg_enable,
        input  npu_state_output_reg_enable,
        input  npu_weight_wr_en,
        input  npu_weight_wr_addr,
        input  npu_weight_wr_data,
        input  npu_cfg_busy,
        input  npu_cfg_error
    );
endinterface

// File: rtl/npu_config_loader.sv
// Drains config FIFO command words, decodes them into state-machine count loads
// and weight-memory writes. One word decoded per cycle; outputs are registered.
module npu_config_loader #(
    parameter int unsigned WADDR_W = 10,
    parameter int unsigned DATA_W  = 16
) (
    input logic             CLK,
    input logic             RST,
    npu_config_loader_if.master bus
);

    typedef enum logic [1:0] {StHdr, StArgIn, StArgOut, StWgt} state_e;

    state_e             state_q;
    logic               rd_valid_q;
    logic [WADDR_W-1:0] waddr_q;
    logic [11:0]        wgt_rem_q;
    logic [DATA_W-1:0]  data_in_q;
    logic               in_en_q;
    logic               out_en_q;
    logic               wr_en_q;
    logic [WADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               error_q;

    logic               read_en;
    logic [DATA_W-1:0]  word;
    logic [3:0]         opcode;
    logic [11:0]        field;

    assign read_en = bus.npu_state_config & ~bus.npu_config_fifo_empty;
    assign word    = bus.npu_config_fifo_dout;
    assign opcode  = word[15:12];
    assign field   = word[11:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StHdr;
            rd_valid_q <= 1'b0;
            waddr_q    <= '0;
            wgt_rem_q  <= '0;
            data_in_q  <= '0;
            in_en_q    <= 1'b0;
            out_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            rd_valid_q <= read_en;
            in_en_q    <= 1'b0;
            out_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            // A returned word is consumed even if config has since dropped.
            if (rd_valid_q) begin
                unique case (state_q)
                    StHdr: begin
                        case (opcode)
                            4'h0: state_q <= StHdr;
                            4'h1: state_q <= StArgIn;
                            4'h2: state_q <= StArgOut;
                            4'h3: begin
                                wgt_rem_q <= field;
                                state_q   <= (field != 12'd0) ? StWgt : StHdr;
                            end
                            4'h4: waddr_q <= field[WADDR_W-1:0];
                            default: error_q <= 1'b1;
                        endcase
                    end
                    StArgIn: begin
                        data_in_q <= word;
                        in_en_q   <= 1'b1;
                        state_q   <= StHdr;
                    end
                    StArgOut: begin
                        data_in_q <= word;
                        out_en_q  <= 1'b1;
                        state_q   <= StHdr;
                    end
                    StWgt: begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= word;
                        wr_addr_q <= waddr_q;
                        waddr_q   <= waddr_q + WADDR_W'(1);
                        wgt_rem_q <= wgt_rem_q - 12'd1;
                        if (wgt_rem_q == 12'd1) begin
                            state_q <= StHdr;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.npu_config_fifo_read_en     = read_en;
    assign bus.npu_state_data_in           = data_in_q;
    assign bus.npu_state_input_reg_enable  = in_en_q;
    assign bus.npu_state_output_reg_enable = out_en_q;
    assign bus.npu_weight_wr_en            = wr_en_q;
    assign bus.npu_weight_wr_addr          = wr_addr_q;
    assign bus.npu_weight_wr_data          = wr_data_q;
    assign bus.npu_cfg_busy                = (state_q != StHdr) | rd_valid_q;
    assign bus.npu_cfg_error               = error_q;

endmodule

// File: tb/tb_npu_config_loader.sv
// Directed bench for npu_config_loader: a queue models the config FIFO with
// one-cycle read latency; each step checks outputs 1 time unit after the edge.
module tb_npu_config_loader;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] fifo[$];

    always #5 clk = ~clk;

    npu_config_loader_if #(.WADDR_W(10), .DATA_W(16)) bus ();

    npu_config_loader #(.WADDR_W(10), .DATA_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo.push_back(w);
        bus.npu_config_fifo_empty = 1'b0;
    endtask

    // One clock; a read strobed at this edge returns its word just after it.
    task automatic tick();
        logic re;
        @(negedge clk);
        re = bus.npu_config_fifo_read_en;
        @(posedge clk);
        #1;
        if (re) bus.npu_config_fifo_dout = fifo.pop_front();
        bus.npu_config_fifo_empty = (fifo.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_wr(input string tag, input logic [9:0] addr, input logic [15:0] data);
        chk({tag, "_en"}, bus.npu_weight_wr_en, 1);
        chk({tag, "_addr"}, bus.npu_weight_wr_addr, addr);
        chk({tag, "_data"}, bus.npu_weight_wr_data, data);
    endtask

    initial begin
        rst = 1'b1;
        bus.npu_state_config      = 1'b0;
        bus.npu_config_fifo_empty = 1'b1;
        bus.npu_config_fifo_dout  = 16'h0;
        ticks(3);
        chk("rst_in_en",  bus.npu_state_input_reg_enable, 0);
        chk("rst_out_en", bus.npu_state_output_reg_enable, 0);
        chk("rst_wr_en",  bus.npu_weight_wr_en, 0);
        chk("rst_addr",   bus.npu_weight_wr_addr, 0);
        chk("rst_wdata",  bus.npu_weight_wr_data, 0);
        chk("rst_data",   bus.npu_state_data_in, 0);
        chk("rst_busy",   bus.npu_cfg_busy, 0);
        chk("rst_err",    bus.npu_cfg_error, 0);
        chk("rst_rd",     bus.npu_config_fifo_read_en, 0);
        rst = 1'b0;
        tick();

        // Input and output count loads, back-to-back reads
        push(16'h1000); push(16'h0008); push(16'h2000); push(16'h0004);
        bus.npu_state_config = 1'b1;
        #1 chk("t1_rd_en", bus.npu_config_fifo_read_en, 1);
        tick();
        chk("t1_busy", bus.npu_cfg_busy, 1);
        chk("t1_in_early", bus.npu_state_input_reg_enable, 0);
        tick();
        chk("t1_in_early2", bus.npu_state_input_reg_enable, 0);
        tick();
        chk("t1_in_en", bus.npu_state_input_reg_enable, 1);
        chk("t1_in_data", bus.npu_state_data_in, 16'h0008);
        chk("t1_out_idle", bus.npu_state_output_reg_enable, 0);
        tick();
        chk("t1_in_pulse", bus.npu_state_input_reg_enable, 0);
        chk("t1_out_early", bus.npu_state_output_reg_enable, 0);
        tick();
        chk("t1_out_en", bus.npu_state_output_reg_enable, 1);
        chk("t1_out_data", bus.npu_state_data_in, 16'h0004);
        chk("t1_in_off", bus.npu_state_input_reg_enable, 0);
        tick();
        chk("t1_out_pulse", bus.npu_state_output_reg_enable, 0);
        chk("t1_data_hold", bus.npu_state_data_in, 16'h0004);
        chk("t1_idle_busy", bus.npu_cfg_busy, 0);

        // SET_WADDR then three weights
        push(16'h4010); push(16'h3003); push(16'h00A1); push(16'h00A2); push(16'h00A3);
        ticks(3);
        chk("t2_no_wr", bus.npu_weight_wr_en, 0);
        chk("t2_busy", bus.npu_cfg_busy, 1);
        tick(); chk_wr("t2_w0", 10'h010, 16'h00A1);
        tick(); chk_wr("t2_w1", 10'h011, 16'h00A2);
        tick(); chk_wr("t2_w2", 10'h012, 16'h00A3);
        chk("t2_busy_end", bus.npu_cfg_busy, 0);
        tick();
        chk("t2_wr_off", bus.npu_weight_wr_en, 0);

        // Address wrap
        push(16'h43FE); push(16'h3003); push(16'h00C1); push(16'h00C2); push(16'h00C3);
        ticks(3);
        tick(); chk_wr("t3_w0", 10'h3FE, 16'h00C1);
        tick(); chk_wr("t3_w1", 10'h3FF, 16'h00C2);
        tick(); chk_wr("t3_w2", 10'h000, 16'h00C3);
        tick();
        chk("t3_wr_off", bus.npu_weight_wr_en, 0);

        // Config drops mid-payload, resumes later
        push(16'h3002); push(16'h00B1);
        ticks(2);
        tick(); chk_wr("t4_w0", 10'h001, 16'h00B1);
        bus.npu_state_config = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_gap_busy", bus.npu_cfg_busy, 1);
            chk("t4_gap_wr", bus.npu_weight_wr_en, 0);
        end
        push(16'h00B2);
        #1 chk("t4_rd_blocked", bus.npu_config_fifo_read_en, 0);
        bus.npu_state_config = 1'b1;
        #1 chk("t4_rd_resume", bus.npu_config_fifo_read_en, 1);
        tick();
        chk("t4_wr_wait", bus.npu_weight_wr_en, 0);
        tick(); chk_wr("t4_w1", 10'h002, 16'h00B2);
        chk("t4_busy_end", bus.npu_cfg_busy, 0);

        // Illegal opcode is sticky and does not block later commands
        push(16'h7123); push(16'h1000); push(16'h0005); push(16'h3000);
        tick();
        chk("t5_err_pre", bus.npu_cfg_error, 0);
        tick();
        chk("t5_err_set", bus.npu_cfg_error, 1);
        ticks(2);
        chk("t5_in_en", bus.npu_state_input_reg_enable, 1);
        chk("t5_in_data", bus.npu_state_data_in, 16'h0005);
        tick();
        chk("t5_zero_wgt_wr", bus.npu_weight_wr_en, 0);
        chk("t5_zero_wgt_busy", bus.npu_cfg_busy, 0);
        tick();
        chk("t5_zero_wgt_wr2", bus.npu_weight_wr_en, 0);
        chk("t5_err_sticky", bus.npu_cfg_error, 1);

        // Reset in the middle of a weight payload
        push(16'h3003); push(16'h00D1);
        ticks(2);
        tick(); chk_wr("t6_w0", 10'h003, 16'h00D1);
        rst = 1'b1;
        tick();
        chk("t6_wr_en", bus.npu_weight_wr_en, 0);
        chk("t6_addr", bus.npu_weight_wr_addr, 0);
        chk("t6_wdata", bus.npu_weight_wr_data, 0);
        chk("t6_data", bus.npu_state_data_in, 0);
        chk("t6_err", bus.npu_cfg_error, 0);
        chk("t6_busy", bus.npu_cfg_busy, 0);

        // A read issued during reset is dropped
        push(16'h1000);
        tick();
        rst = 1'b0;
        push(16'h0009);
        tick();
        tick();
        chk("t6_discard_a", bus.npu_state_input_reg_enable, 0);
        tick();
        chk("t6_discard_b", bus.npu_state_input_reg_enable, 0);
        chk("t6_discard_busy", bus.npu_cfg_busy, 0);

        // Post-reset words decode from HDR with waddr cleared
        push(16'h1000); push(16'h0007);
        ticks(2);
        tick();
        chk("t6_hdr_in_en", bus.npu_state_input_reg_enable, 1);
        chk("t6_hdr_data", bus.npu_state_data_in, 16'h0007);
        chk("t6_hdr_no_wr", bus.npu_weight_wr_en, 0);
        push(16'h3001); push(16'h00E1);
        ticks(2);
        tick(); chk_wr("t6_w_after", 10'h000, 16'h00E1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
